// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial A - B - Bin, one bit per clock, start/busy/done
// Option macro: SERIAL_SUB_SAT_EN (clamp Diff to 0 on unsigned underflow)
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_br;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [CW-1:0]    r_cnt;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_diff_full;

  // Full-subtractor cell on the current LSBs
  assign w_a         = r_a_sr[0];
  assign w_b         = r_b_sr[0];
  assign w_d         = w_a ^ w_b ^ r_br;
  assign w_br_next   = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
  assign w_diff_full = {w_d, r_res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_br     <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Diff     <= '0;
      Bout     <= 1'b0;
      Ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr  <= A;
            r_b_sr  <= B;
            r_br    <= Bin;
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= w_diff_full;
          r_br     <= w_br_next;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == C_LAST) begin
            // Results are taken from the final bit's combinational values
`ifdef SERIAL_SUB_SAT_EN
            Diff <= w_br_next ? '0 : w_diff_full;
`else
            Diff <= w_diff_full;
`endif
            Bout    <= w_br_next;
            Ovf     <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference.
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Ovf;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout),
    .Ovf   (Ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bo, output logic ov);
    int r;
    logic [7:0] wrapped;
    r       = int'(a) - int'(b) - int'(bin);
    bo      = (r < 0);
    wrapped = 8'((r + 512) % 256);
    ov      = (a[7] != b[7]) && (wrapped[7] != a[7]);
`ifdef SERIAL_SUB_SAT_EN
    d = bo ? 8'h00 : wrapped;
`else
    d = wrapped;
`endif
  endtask

  // Runs one operation and reports what was seen, edges counted from the accepting edge
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] d, output logic bo, output logic ov,
                        output logic busy_at_done, output int lat, output int pulses);
    d = 'x; bo = 1'bx; ov = 1'bx; busy_at_done = 1'bx;
    lat = -1; pulses = 0;
    @(negedge clk);
    start = 1'b1; A = a; B = b; Bin = bin;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
    for (int k = 1; k <= WIDTH + 3; k++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = k; d = Diff; bo = Bout; ov = Ovf; busy_at_done = busy;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (Diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff: got %h expected 00", Diff); end
    n_checks++; if (Bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout: got %b expected 0", Bout); end
    n_checks++; if (Ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", Ovf); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] d; logic bo, ov, bz; int lat, p;
    run_op(8'h3C, 8'h15, 1'b0, d, bo, ov, bz, lat, p);
    n_checks++; if (lat !== WIDTH) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, WIDTH); end
    n_checks++; if (d !== 8'h27) begin n_fail++; $display("FAIL basic_diff: got %h expected 27", d); end
    n_checks++; if (bo !== 1'b0 || ov !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got bout=%b ovf=%b expected 0 0", bo, ov); end
    n_checks++; if (bz !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_done: got %b expected 0", bz); end
    n_checks++; if (p !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d expected 1", p); end
  endtask

  task automatic test_boundaries;
    logic [7:0] va [3] = '{8'h10, 8'h80, 8'h00};
    logic [7:0] vb [3] = '{8'h20, 8'h01, 8'h00};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] d, ed; logic bo, ov, bz, ebo, eov; int lat, p;
    for (int i = 0; i < 3; i++) begin
      model(va[i], vb[i], vc[i], ed, ebo, eov);
      run_op(va[i], vb[i], vc[i], d, bo, ov, bz, lat, p);
      n_checks++;
      if (lat !== WIDTH || d !== ed || bo !== ebo || ov !== eov) begin
        n_fail++;
        $display("FAIL boundary_%0d: got lat=%0d diff=%h bout=%b ovf=%b expected lat=%0d diff=%h bout=%b ovf=%b",
                 i, lat, d, bo, ov, WIDTH, ed, ebo, eov);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b, d, ed; logic bin, bo, ov, bz, ebo, eov; int lat, p;
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      model(a, b, bin, ed, ebo, eov);
      run_op(a, b, bin, d, bo, ov, bz, lat, p);
      n_checks++;
      if (lat !== WIDTH || p !== 1 || d !== ed || bo !== ebo || ov !== eov) begin
        n_fail++;
        $display("FAIL random_%0d %h-%h-%b: got lat=%0d pulses=%0d diff=%h bout=%b ovf=%b expected lat=%0d pulses=1 diff=%h bout=%b ovf=%b",
                 i, a, b, bin, lat, p, d, bo, ov, WIDTH, ed, ebo, eov);
      end
    end
  endtask

  task automatic test_start_ignored;
    int pulses = 0;
    @(negedge clk);
    start = 1'b1; A = 8'h55; B = 8'h11; Bin = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept: got %b expected 1", busy); end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) begin
        start = 1'b1; A = 8'hFF; B = 8'hFF; Bin = 1'b1;
      end else if (k >= 8 && k <= 10) begin
        start = 1'b1; A = 8'h3C; B = 8'h15; Bin = 1'b0;
      end else begin
        start = 1'b0; A = 8'($urandom); B = 8'($urandom);
      end
      @(posedge clk); #1;
      if (k <= 9 && done) pulses++;
      if (k == 8) begin
        n_checks++;
        if (done !== 1'b1 || Diff !== 8'h44) begin
          n_fail++; $display("FAIL ignore_result: got done=%b diff=%h expected done=1 diff=44", done, Diff);
        end
      end
      if (k == 9) begin
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          n_fail++; $display("FAIL start_in_done_ignored: got busy=%b done=%b expected 0 0", busy, done);
        end
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
      end
      if (k == 10) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL accept_after_idle: got busy=%b expected 1", busy); end
      end
      if (k == 18) begin
        n_checks++;
        if (done !== 1'b1 || Diff !== 8'h27) begin
          n_fail++; $display("FAIL followup_result: got done=%b diff=%h expected done=1 diff=27", done, Diff);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d; logic bo, ov, bz; int lat, p;
    int stray = 0;
    run_op(8'h3C, 8'h15, 1'b0, d, bo, ov, bz, lat, p);
    n_checks++; if (d !== 8'h27) begin n_fail++; $display("FAIL pre_reset_diff: got %h expected 27", d); end
    @(negedge clk);
    start = 1'b1; A = 8'hAA; B = 8'h01; Bin = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Diff !== 8'h00 || Bout !== 1'b0 || Ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b diff=%h bout=%b ovf=%b expected all 0", busy, done, Diff, Bout, Ovf);
    end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (done) stray++; end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL reset_no_done: got %0d pulses expected 0", stray); end
    run_op(8'h3C, 8'h15, 1'b0, d, bo, ov, bz, lat, p);
    n_checks++;
    if (lat !== WIDTH || d !== 8'h27) begin
      n_fail++; $display("FAIL post_reset_op: got lat=%0d diff=%h expected lat=%0d diff=27", lat, d, WIDTH);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_random();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
